// File: rtl/ds_mod1_dac.sv
// ds_mod1_dac -- first-order delta-sigma DAC modulator.
//
// Accepts unsigned PCM samples over a valid/ready handshake, holds each
// sample for 2^OSR_LOG2 enabled modulator cycles and emits a 1-bit density
// coded bitstream taken from the carry-out of a WIDTH-bit ripple accumulator.
//
// Ports:
//   CLK           in   clock, all state updates on the rising edge
//   RST           in   synchronous active-high reset
//   EN            in   modulator enable; low freezes the modulator (not the handshake)
//   DIN           in   [WIDTH-1:0] unsigned sample
//   DIN_VALID     in   DIN is valid this cycle
//   DIN_READY     out  pending buffer empty
//   DOUT          out  registered bitstream bit
//   SAMPLE_TICK   out  one-cycle pulse after a sample enters the hold register
//   UNDERRUN      out  sticky: no sample was pending at a hold boundary
//   UNDERRUN_CLR  in   clears UNDERRUN (a coincident set wins)
//
// State | meaning
// IDLE  | waiting for the first sample after reset; ACC and DOUT frozen
// RUN   | modulating; never left except through RST

module FA (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ds_mod1_dac #(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             DOUT,
  output logic             SAMPLE_TICK,
  output logic             UNDERRUN,
  input  logic             UNDERRUN_CLR
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      p_q, p_d;
  logic                  p_full_q, p_full_d;
  logic [WIDTH-1:0]      h_q, h_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [OSR_LOG2-1:0]   cnt_q, cnt_d;
  logic                  dout_q, dout_d;
  logic                  tick_q, tick_d;
  logic                  underrun_q, underrun_d;

  logic [WIDTH-1:0]      sum;
  logic [WIDTH:0]        carry;
  logic                  accept;
  logic                  boundary;

  // Ripple accumulator: carry-out of ACC + H is the output bit.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    FA u_fa (
      .a  (acc_q[i]),
      .b  (h_q[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Acceptance only when the buffer is empty, so it can never collide with
  // a P->H transfer (which requires the buffer to be full).
  assign accept   = DIN_VALID & ~p_full_q;
  assign boundary = (cnt_q == {OSR_LOG2{1'b1}});

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      p_q        <= '0;
      p_full_q   <= 1'b0;
      h_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      dout_q     <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      p_full_q   <= p_full_d;
      h_q        <= h_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    p_full_d   = p_full_q;
    h_d        = h_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    tick_d     = 1'b0;
    underrun_d = underrun_q & ~UNDERRUN_CLR;

    if (accept) begin
      p_d      = DIN;
      p_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (EN && p_full_q) begin
          h_d      = p_q;
          p_full_d = 1'b0;
          cnt_d    = '0;
          tick_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (EN) begin
          acc_d  = sum;
          dout_d = carry[WIDTH];
          cnt_d  = cnt_q + 1'b1;
          if (boundary) begin
            if (p_full_q) begin
              h_d      = p_q;
              p_full_d = 1'b0;
              tick_d   = 1'b1;
            end else begin
              // Starved: keep repeating the held sample and flag it.
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign DIN_READY   = ~p_full_q;
  assign DOUT        = dout_q;
  assign SAMPLE_TICK = tick_q;
  assign UNDERRUN    = underrun_q;

endmodule
